// File: rtl/alu_sequencer_if.sv
// Request/response handshake bundle for alu_sequencer.
// The master issues operations and consumes results; the sequencer is the slave.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_count;
  logic        req_usec;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_flags;

  modport master (
    output req_valid, req_op, req_a, req_b, req_count, req_usec, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_flags
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_count, req_usec, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// Execute-stage sequencer around an external combinational 16-bit ALU.
// Optional ALU_SEQ_KEEP_C_EN: logical ops leave PSW.C untouched.
module alu_sequencer (
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  bus,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [2:0]      alu_func,
  output logic            cin,
  input  logic [15:0]     alu_out,
  input  logic            c,
  input  logic            z,
  input  logic            v,
  input  logic            s,
  output logic [3:0]      flags,
  output logic            busy
);

  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;
    logic        usec;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q;
  logic [15:0] work_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cap_q;
  logic [3:0]  psw_q;
  logic [3:0]  psw_nxt;
  logic        accept;
  logic        is_shift;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign is_shift = (bus.req_op == OP_SHL) || (bus.req_op == OP_SHR);

`ifdef ALU_SEQ_KEEP_C_EN
  logic logic_op;
  assign logic_op = (req_q.op == 3'b010) || (req_q.op == 3'b011) ||
                    (req_q.op == 3'b100) || (req_q.op == OP_RSV);
  assign psw_nxt  = {logic_op ? psw_q[3] : c, z, v, s};
`else
  assign psw_nxt  = {c, z, v, s};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_func      = OP_RSV;
    cin           = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = EXEC;
      end
      EXEC: begin
        alu_a    = req_q.a;
        alu_b    = work_q;
        alu_func = req_q.op;
        // PSW only moves on the last EXEC edge, so it is stable for the whole op
        cin      = req_q.usec & psw_q[3];
        if (cnt_q == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      cap_q  <= '0;
      psw_q  <= '0;
    end else if (accept) begin
      req_q  <= {bus.req_op, bus.req_a, bus.req_usec};
      work_q <= bus.req_b;
      cnt_q  <= is_shift ? bus.req_count : 4'd0;
    end else if (state == EXEC) begin
      work_q <= alu_out;
      cap_q  <= {c, z, v, s};
      if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      else               psw_q <= psw_nxt;
    end
  end

  assign bus.rsp_data  = work_q;
  assign bus.rsp_flags = cap_q;
  assign flags         = psw_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed scoreboard bench for alu_sequencer with a behavioural 16-bit ALU.
// The bench ALU reports V as the carry/borrow into bit 15 for ADD/SUB.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_func;
  logic        cin, c, z, v, s;
  logic [3:0]  flags;
  logic        busy;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .cin(cin),
    .alu_out(alu_out), .c(c), .z(z), .v(v), .s(s),
    .flags(flags), .busy(busy)
  );

`ifdef ALU_SEQ_KEEP_C_EN
  localparam bit KEEP_C = 1'b1;
`else
  localparam bit KEEP_C = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] wide;
  always_comb begin
    wide    = '0;
    alu_out = '0;
    c       = 1'b0;
    v       = 1'b0;
    case (alu_func)
      3'b000: begin
        wide    = {1'b0, alu_b} + {1'b0, alu_a} + {16'd0, cin};
        alu_out = wide[15:0];
        c       = wide[16];
        v       = alu_a[15] ^ alu_b[15] ^ wide[15];
      end
      3'b001: begin
        wide    = {1'b0, alu_b} - {1'b0, alu_a} - {16'd0, cin};
        alu_out = wide[15:0];
        c       = wide[16];
        v       = alu_a[15] ^ alu_b[15] ^ wide[15];
      end
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a | alu_b;
      3'b100: alu_out = alu_a ^ alu_b;
      3'b101: begin alu_out = {alu_b[14:0], 1'b0}; c = alu_b[15]; end
      3'b110: begin alu_out = {1'b0, alu_b[15:1]}; c = alu_b[0];  end
      default: alu_out = '0;
    endcase
    z = (alu_out == 16'd0);
    s = alu_out[15];
  end

  typedef struct {
    logic [15:0] d;
    logic [3:0]  f;
    logic [3:0]  p;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exec_b[$];
  logic        exec_cin[$];
  int          vectors = 0;
  int          errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops an expectation on every response handshake
  always @(negedge clk) begin
    if (rst_n && busy && !bus.rsp_valid) begin
      exec_b.push_back(alu_b);
      exec_cin.push_back(cin);
    end
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_data",  {16'd0, bus.rsp_data}, {16'd0, e.d});
        chk("rsp_flags", {28'd0, bus.rsp_flags}, {28'd0, e.f});
        chk("psw",       {28'd0, flags},        {28'd0, e.p});
      end
    end
  end

  // issue one op, return at the first point rsp_valid is seen; handshake if rsp_ready
  task automatic issue(input string name, input logic [2:0] op, input logic [15:0] a, b,
                       input logic [3:0] cnt, input logic usec,
                       input logic [15:0] ed, input logic [3:0] ef, ep, input int elat);
    int n;
    exp_t e;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({name, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
    exec_b.delete();
    exec_cin.delete();
    e.d = ed; e.f = ef; e.p = ep;
    sb.push_back(e);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    bus.req_count = cnt;  bus.req_usec = usec;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) bus.req_valid = 1'b0;
    end while (!bus.rsp_valid && n < 40);
    chk({name, "_latency"}, n, elat);
    if (bus.rsp_ready) begin
      @(posedge clk); #1;
      chk({name, "_ready_after_hs"}, {31'd0, bus.req_ready}, 32'd1);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_count = '0;   bus.req_usec = 1'b0; bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},          32'd0);
    chk("rst_drive",     {alu_func, cin, alu_a[11:0], alu_b}, {3'b111, 1'b0, 28'd0});
    rst_n = 1'b1;

    issue("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 4'd5, 1'b0, 16'h8000, 4'b0011, 4'b0011, 2);
    issue("add_cy",  3'b000, 16'h0001, 16'hFFFF, 4'd0, 1'b0, 16'h0000, 4'b1110, 4'b1110, 2);
    issue("adc",     3'b000, 16'h0000, 16'h0001, 4'd0, 1'b1, 16'h0002, 4'b0000, 4'b0000, 2);
    chk("adc_cin", {31'd0, exec_cin[0]}, 32'd1);
    issue("sub",     3'b001, 16'h0005, 16'h0003, 4'd0, 1'b0, 16'hFFFE, 4'b1011, 4'b1011, 2);
    issue("rsv",     3'b111, 16'h1234, 16'h5678, 4'd9, 1'b1, 16'h0000, 4'b0100, {KEEP_C, 3'b100}, 2);
    issue("shl3",    3'b101, 16'h0000, 16'h1001, 4'd3, 1'b0, 16'h0010, 4'b1000, 4'b1000, 5);
    chk("shl3_passes", exec_b.size(), 4);
    if (exec_b.size() == 4) begin
      chk("shl3_b0", {16'd0, exec_b[0]}, 32'h1001);
      chk("shl3_b1", {16'd0, exec_b[1]}, 32'h2002);
      chk("shl3_b2", {16'd0, exec_b[2]}, 32'h4004);
      chk("shl3_b3", {16'd0, exec_b[3]}, 32'h8008);
    end
    issue("shr15",   3'b110, 16'h0000, 16'h0001, 4'd15, 1'b0, 16'h0000, 4'b0100, 4'b0100, 17);
    issue("or",      3'b011, 16'h00F0, 16'h0F00, 4'd2, 1'b0, 16'h0FF0, 4'b0000, 4'b0000, 2);
    issue("xor",     3'b100, 16'hFFFF, 16'hFFFF, 4'd0, 1'b0, 16'h0000, 4'b0100, 4'b0100, 2);

    // backpressure: hold the result, present a stray request that must be dropped
    bus.rsp_ready = 1'b0;
    issue("bp", 3'b000, 16'h0002, 16'h0003, 4'd0, 1'b0, 16'h0005, 4'b0000, 4'b0000, 2);
    bus.req_valid = 1'b1; bus.req_op = 3'b011; bus.req_a = 16'hAAAA; bus.req_b = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_data",      {16'd0, bus.rsp_data},  32'h0005);
      chk("bp_flags",     {28'd0, bus.rsp_flags}, 32'h0);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("bp_valid",     {31'd0, bus.rsp_valid}, 32'd1);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("bp_not_latched", {31'd0, busy}, 32'd0);

    issue("k_add", 3'b000, 16'h0001, 16'hFFFF, 4'd0, 1'b0, 16'h0000, 4'b1110, 4'b1110, 2);
    issue("k_and", 3'b010, 16'h00FF, 16'h0F0F, 4'd0, 1'b0, 16'h000F, 4'b0000, {KEEP_C, 3'b000}, 2);

    // abort a long shift with reset after PSW.C has been set
    issue("r_add", 3'b000, 16'h0001, 16'hFFFF, 4'd0, 1'b0, 16'h0000, 4'b1110, 4'b1110, 2);
    bus.req_valid = 1'b1; bus.req_op = 3'b101; bus.req_a = '0; bus.req_b = 16'h00FF;
    bus.req_count = 4'd7; bus.req_usec = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("r_busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("r_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("r_busy",      {31'd0, busy},          32'd0);
    chk("r_data",      {16'd0, bus.rsp_data},  32'd0);
    chk("r_flags",     {24'd0, bus.rsp_flags, flags}, 32'd0);
    chk("r_drive",     {alu_func, cin, alu_a[11:0], alu_b}, {3'b111, 1'b0, 28'd0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("r_ready_after", {31'd0, bus.req_ready}, 32'd1);
    issue("r_adc", 3'b000, 16'h0001, 16'h0001, 4'd0, 1'b1, 16'h0002, 4'b0000, 4'b0000, 2);

    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
